// File: rtl/jskid_buffer_pkg.sv
// jskid_buffer_pkg: state encoding and default width shared by the skid buffer and its checker
package jskid_buffer_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;
    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/jskid_checker.sv
// jskid_checker: 2-deep reference queue that flags any output word differing from the accepted order
module jskid_checker
    import jskid_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             push,
    input  logic [WIDTH-1:0] y,
    input  logic             pop,
    output logic             mismatch
);
    logic [WIDTH-1:0] q0, q1, q0_n, q1_n;
    logic [1:0]       cnt, cnt_sh;
    logic             bad;

    // Pop first, then the pushed word lands in the first free slot.
    assign cnt_sh = cnt - {1'b0, pop};
    assign q0_n   = (push && cnt_sh == 2'd0) ? a : (pop ? q1 : q0);
    assign q1_n   = (push && cnt_sh != 2'd0) ? a : q1;
    assign bad    = pop && (cnt == 2'd0 || y != q0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0       <= '0;
            q1       <= '0;
            cnt      <= 2'd0;
            mismatch <= 1'b0;
        end else begin
            q0       <= q0_n;
            q1       <= q1_n;
            cnt      <= cnt_sh + {1'b0, push};
            mismatch <= mismatch | bad;
        end
    end
endmodule

// File: rtl/jskid_buffer.sv
// jskid_buffer: 2-entry skid buffer with registered a_ready and optional in-order self-check
module jskid_buffer
    import jskid_buffer_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHECK_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [1:0]       count,
    output logic             mismatch
);
    state_t           state, state_n;
    logic [WIDTH-1:0] m, s, m_n, s_n;
    logic             xfer_in, xfer_out;

    assign xfer_in  = a_valid && a_ready;
    assign xfer_out = y_valid && y_ready;
    assign y_valid  = state != EMPTY;
    assign y        = m;
    assign count    = 2'(state);

    always_comb begin
        state_n = state;
        m_n     = m;
        s_n     = s;
        case (state)
            EMPTY: if (xfer_in) begin
                state_n = ONE;
                m_n     = a;
            end
            ONE: if (xfer_in && xfer_out) begin
                m_n = a;
            end else if (xfer_in) begin
                state_n = FULL;
                s_n     = a;
            end else if (xfer_out) begin
                state_n = EMPTY;
            end
            FULL: if (xfer_out) begin
                state_n = ONE;
                m_n     = s;
            end
            default: state_n = EMPTY;
        endcase
    end

    // a_ready is a flop so y_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            m       <= '0;
            s       <= '0;
            a_ready <= 1'b0;
        end else begin
            state   <= state_n;
            m       <= m_n;
            s       <= s_n;
            a_ready <= state_n != FULL;
        end
    end

    if (CHECK_EN != 0) begin : g_chk
        jskid_checker #(.WIDTH(WIDTH)) u_chk (
            .clk      (clk),
            .rst_n    (rst_n),
            .a        (a),
            .push     (xfer_in),
            .y        (y),
            .pop      (xfer_out),
            .mismatch (mismatch)
        );
    end else begin : g_nochk
        assign mismatch = 1'b0;
    end
endmodule

// File: tb/tb_jskid_buffer.sv
// tb_jskid_buffer: directed and random checks of jskid_buffer against a queue-based model
module tb_jskid_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'h00;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready = 1'b0;
    logic [1:0] count;
    logic       mismatch;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    bit         fresh = 1'b1;
    bit         exp_mm = 1'b0;
    int         sent = 0;
    int         outs = 0;

    jskid_buffer #(.WIDTH(8), .CHECK_EN(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .count    (count),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model view: the buffer holds q in acceptance order; it can take a word while fewer
    // than two are held, except on the very first edge after reset.
    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("a_ready", 32'(a_ready), 32'(!fresh && q.size() < 2));
        chk("y_valid", 32'(y_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("y", 32'(y), 32'(q[0]));
        chk("mismatch", 32'(mismatch), 32'(exp_mm));
    endtask

    task automatic model_edge();
        bit tin, tout;
        if (rst_n) begin
            tin  = a_valid && !fresh && q.size() < 2;
            tout = q.size() > 0 && y_ready;
            if (tout) begin
                void'(q.pop_front());
                outs++;
            end
            if (tin) begin
                q.push_back(a);
                sent++;
            end
            fresh = 1'b0;
        end
    endtask

    task automatic cycle(input logic [7:0] d, input logic v, input logic r);
        a = d;
        a_valid = v;
        y_ready = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        fresh = 1'b1;
        exp_mm = 1'b0;
        check_all();
        chk("rst_y", 32'(y), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'h00, 1'b0, 1'b0);
        chk("rst_a_ready_rise", 32'(a_ready), 32'h1);
    endtask

    initial begin
        int base, budget;
        logic [7:0] py;
        logic pv, stall, v, r;
        @(negedge clk);
        do_reset();

        // single word latency
        cycle(8'h5A, 1'b1, 1'b1);
        chk("lat_y", 32'(y), 32'h5A);
        chk("lat_valid", 32'(y_valid), 32'h1);
        chk("lat_count1", 32'(count), 32'h1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("lat_count0", 32'(count), 32'h0);

        // full-rate stream
        for (int i = 0; i < 16; i++) begin
            cycle(8'(i), 1'b1, 1'b1);
            chk("tp_a_ready", 32'(a_ready), 32'h1);
            chk("tp_y", 32'(y), 32'(i));
        end
        cycle(8'h00, 1'b0, 1'b1);
        chk("tp_drained", 32'(count), 32'h0);
        chk("tp_mismatch", 32'(mismatch), 32'h0);

        // stall fills the skid
        cycle(8'hA1, 1'b1, 1'b0);
        cycle(8'hA2, 1'b1, 1'b0);
        chk("stall_count", 32'(count), 32'h2);
        chk("stall_a_ready", 32'(a_ready), 32'h0);
        chk("stall_y", 32'(y), 32'hA1);
        cycle(8'hFF, 1'b1, 1'b0);
        chk("stall_hold_y", 32'(y), 32'hA1);
        chk("stall_hold_count", 32'(count), 32'h2);
        cycle(8'h00, 1'b0, 1'b1);
        chk("release_y", 32'(y), 32'hA2);
        chk("release_a_ready", 32'(a_ready), 32'h1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("release_empty", 32'(count), 32'h0);

        // random traffic
        base = outs;
        sent = 0;
        budget = 0;
        while ((sent < 1000 || q.size() > 0) && budget < 20000) begin
            pv = y_valid;
            py = y;
            v = (sent < 1000) && ($urandom_range(3) != 0);
            r = $urandom_range(2) != 0;
            stall = pv && !r;
            cycle(8'($urandom), v, r);
            if (stall) begin
                chk("rand_stable_v", 32'(y_valid), 32'(pv));
                chk("rand_stable_y", 32'(y), 32'(py));
            end
            budget++;
        end
        chk("rand_budget", 32'(budget < 20000), 32'h1);
        chk("rand_outs", 32'(outs - base), 32'd1000);
        chk("rand_mismatch", 32'(mismatch), 32'h0);

        // reset while full
        cycle(8'h11, 1'b1, 1'b0);
        cycle(8'h22, 1'b1, 1'b0);
        chk("full_before_rst", 32'(count), 32'h2);
        do_reset();
        cycle(8'h3C, 1'b1, 1'b0);
        chk("post_rst_y", 32'(y), 32'h3C);
        chk("post_rst_count", 32'(count), 32'h1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("post_rst_alone", 32'(y_valid), 32'h0);

        // corrupt the output word during one transfer out
        cycle(8'h77, 1'b1, 1'b0);
        chk("pre_fault_mm", 32'(mismatch), 32'h0);
        force dut.m = 8'h88;
        exp_mm = 1'b1;
        cycle(8'h00, 1'b0, 1'b1);
        release dut.m;
        chk("fault_mm", 32'(mismatch), 32'h1);
        cycle(8'h55, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("fault_sticky", 32'(mismatch), 32'h1);
        do_reset();
        chk("fault_cleared", 32'(mismatch), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jskid_buffer.md
JSKID_BUFFER -- requirements
Module: jskid_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data bits per transfer.
REQ-002 Parameter CHECK_EN, default 1; when 1, the block compares each output word against its input word.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a  input  WIDTH  upstream data word.
REQ-006 a_valid  input  1  upstream word present on a.
REQ-007 a_ready  output  1  block can accept a word this cycle.
REQ-008 y  output  WIDTH  downstream data word.
REQ-009 y_valid  output  1  y holds a valid word.
REQ-010 y_ready  input  1  downstream accepts y this cycle.
REQ-011 count  output  2  words held (0..2).
REQ-012 mismatch  output  1  sticky flag, set by the CHECK_EN comparison.

Function
REQ-013 Transfer in occurs when a_valid && a_ready at a rising edge; transfer out occurs when y_valid && y_ready at a rising edge.
REQ-014 Storage is a 2-entry skid: main register M drives y; skid register S absorbs one word when downstream stalls.
REQ-015 States: EMPTY (count 0), ONE (M valid), FULL (M and S valid).
REQ-016 EMPTY: on in -> ONE, M<=a.
REQ-017 ONE: in and out together -> ONE, M<=a.
REQ-018 ONE: in only -> FULL, S<=a.
REQ-019 ONE: out only -> EMPTY.
REQ-020 FULL: out -> ONE, M<=S; a_ready=0, so no in occurs.
REQ-021 a_ready = (state != FULL), registered (no combinational path from y_ready).
REQ-022 y_valid = (state != EMPTY); y = M.
REQ-023 Latency: a word accepted in EMPTY appears on y with y_valid one cycle later.
REQ-024 Throughput: one word per cycle when y_ready is held high.
REQ-025 Order preserved: words leave in acceptance order, none dropped or duplicated.
REQ-026 y and y_valid are stable while y_valid && !y_ready.
REQ-027 a_valid while a_ready=0 has no effect.
REQ-028 Mismatch checking applies only when CHECK_EN=1.
REQ-029 Each accepted word is pushed into a 2-deep reference queue.
REQ-030 On each out, the output word is compared with the queue head.
REQ-031 Any difference sets mismatch, which holds until reset.

Reset
REQ-032 rst_n low immediately forces state EMPTY, count 0, a_ready 0, y_valid 0, y 0, mismatch 0 and the reference queue empty.
REQ-033 a_ready rises on the first clock edge after rst_n deasserts.
REQ-034 Reset asserted mid-transfer discards all held words; no partial word is emitted.

Structure
REQ-035 A shared package holds the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the WIDTH default.
REQ-036 The reference queue and comparator are one sub-module, jskid_checker, instantiated only when CHECK_EN=1; otherwise mismatch is tied to 0.

Verification
REQ-037 Reset then a=8'h5A, a_valid=1 for 1 cycle with y_ready=1 -> y=8'h5A and y_valid=1 on the next cycle; count 1 then 0.
REQ-038 Stream 8'h00..8'h0F with y_ready=1 -> 16 outputs in order, one per cycle, a_ready=1 throughout, mismatch=0.
REQ-039 y_ready=0 and send 8'hA1, 8'hA2 -> count=2, a_ready=0, y=8'hA1 held; release y_ready -> A1 then A2 out, a_ready returns to 1.
REQ-040 Random a_valid/y_ready (1000 words) -> scoreboard equality, no drops or duplicates, y stable while stalled, mismatch=0.
REQ-041 Assert rst_n=0 while FULL -> count=0 and y_valid=0 immediately; after release, next word 8'h3C emerges alone.
REQ-042 Force y to differ via fault injection (CHECK_EN=1) -> mismatch=1 after that out, and it stays 1 until rst_n.
